// File: rtl/usb_fs_rx_out_buffer.sv
// usb_fs_rx_out_buffer: captures OUT/SETUP data payloads into a single-packet buffer and reports ack/nak/err
// Ports: clk, reset (async, active-high); dev_addr; receiver side pkt_start, pkt_end, pid, addr, endp,
//        rx_data_put, rx_data, valid_packet; consumer side rd_addr -> rd_data (1-cycle), buf_release,
//        buf_full, buf_len, buf_pid, buf_endp, buf_setup; handshake pulses rx_ack, rx_nak, rx_err.
module usb_fs_rx_out_buffer #(
    parameter int MAX_PKT = 64,
    parameter int NUM_EP  = 4,
    parameter int CNT_W   = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       dev_addr,
    input  logic             pkt_start,
    input  logic             pkt_end,
    input  logic [3:0]       pid,
    input  logic [6:0]       addr,
    input  logic [3:0]       endp,
    input  logic             rx_data_put,
    input  logic [7:0]       rx_data,
    input  logic             valid_packet,
    input  logic [CNT_W-1:0] rd_addr,
    output logic [7:0]       rd_data,
    input  logic             buf_release,
    output logic             buf_full,
    output logic [CNT_W-1:0] buf_len,
    output logic [3:0]       buf_pid,
    output logic [3:0]       buf_endp,
    output logic             buf_setup,
    output logic             rx_ack,
    output logic             rx_nak,
    output logic             rx_err
);
    localparam logic [3:0]       PID_OUT   = 4'b0001;
    localparam logic [3:0]       PID_SETUP = 4'b1101;
    localparam logic [3:0]       PID_DATA0 = 4'b0011;
    localparam logic [3:0]       PID_DATA1 = 4'b1011;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(MAX_PKT + 2);
    localparam logic [4:0]       EP_LIM    = 5'(NUM_EP);

    typedef enum logic [1:0] {IDLE, WAIT_DATA, RECV, CHECK} state_t;

    state_t           state_q, state_d;
    logic             drop_q, drop_d, ovf_q, ovf_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [3:0]       tok_endp_q, tok_endp_d, dpid_q, dpid_d;
    logic             tok_setup_q, tok_setup_d;
    logic             buf_full_q, buf_full_d, buf_setup_q, buf_setup_d;
    logic [CNT_W-1:0] buf_len_q, buf_len_d;
    logic [3:0]       buf_pid_q, buf_pid_d, buf_endp_q, buf_endp_d;
    logic             rx_ack_q, rx_ack_d, rx_nak_q, rx_nak_d, rx_err_q, rx_err_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             we, tok_match, data_ok;
    logic [7:0]       mem [0:MAX_PKT+1];

    assign tok_match = pkt_end && (pid == PID_OUT || pid == PID_SETUP) && addr == dev_addr
                       && {1'b0, endp} < EP_LIM;
    assign data_ok   = valid_packet && (dpid_q == PID_DATA0 || dpid_q == PID_DATA1);
    assign rd_data_d = (rd_addr < FULL_CNT) ? mem[rd_addr] : 8'h00;

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        ovf_d       = ovf_q;
        wr_cnt_d    = wr_cnt_q;
        tok_endp_d  = tok_endp_q;
        tok_setup_d = tok_setup_q;
        dpid_d      = dpid_q;
        buf_full_d  = buf_full_q && !buf_release;
        buf_len_d   = buf_len_q;
        buf_pid_d   = buf_pid_q;
        buf_endp_d  = buf_endp_q;
        buf_setup_d = buf_setup_q;
        rx_ack_d    = 1'b0;
        rx_nak_d    = 1'b0;
        rx_err_d    = 1'b0;
        we          = 1'b0;
        case (state_q)
            IDLE: if (tok_match) begin
                tok_endp_d  = endp;
                tok_setup_d = pid == PID_SETUP;
                drop_d      = buf_full_q;
                state_d     = WAIT_DATA;
            end
            WAIT_DATA: if (pkt_start) begin
                wr_cnt_d = '0;
                ovf_d    = 1'b0;
                state_d  = RECV;
            end else if (pkt_end) begin
                state_d = IDLE;
            end
            RECV: if (pkt_start) begin
                wr_cnt_d = '0;
                ovf_d    = 1'b0;
            end else begin
                if (rx_data_put && !drop_q) begin
                    we       = wr_cnt_q < FULL_CNT;
                    wr_cnt_d = we ? wr_cnt_q + 1'b1 : wr_cnt_q;
                    ovf_d    = ovf_q || !we;
                end
                if (pkt_end) begin
                    dpid_d  = pid;
                    state_d = CHECK;
                end
            end
            default: begin
                state_d = IDLE;
                if (data_ok && !drop_q && !ovf_q && wr_cnt_q >= CNT_W'(2)) begin
                    buf_full_d  = 1'b1;
                    buf_len_d   = wr_cnt_q - CNT_W'(2);
                    buf_pid_d   = dpid_q;
                    buf_endp_d  = tok_endp_q;
                    buf_setup_d = tok_setup_q;
                    rx_ack_d    = 1'b1;
                end else if (data_ok && drop_q) begin
                    rx_nak_d = 1'b1;
                end else begin
                    rx_err_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            ovf_q       <= 1'b0;
            wr_cnt_q    <= '0;
            tok_endp_q  <= '0;
            tok_setup_q <= 1'b0;
            dpid_q      <= '0;
            buf_full_q  <= 1'b0;
            buf_len_q   <= '0;
            buf_pid_q   <= '0;
            buf_endp_q  <= '0;
            buf_setup_q <= 1'b0;
            rx_ack_q    <= 1'b0;
            rx_nak_q    <= 1'b0;
            rx_err_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            ovf_q       <= ovf_d;
            wr_cnt_q    <= wr_cnt_d;
            tok_endp_q  <= tok_endp_d;
            tok_setup_q <= tok_setup_d;
            dpid_q      <= dpid_d;
            buf_full_q  <= buf_full_d;
            buf_len_q   <= buf_len_d;
            buf_pid_q   <= buf_pid_d;
            buf_endp_q  <= buf_endp_d;
            buf_setup_q <= buf_setup_d;
            rx_ack_q    <= rx_ack_d;
            rx_nak_q    <= rx_nak_d;
            rx_err_q    <= rx_err_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // payload RAM is deliberately not reset
    always_ff @(posedge clk)
        if (we) mem[wr_cnt_q] <= rx_data;

    assign rd_data   = rd_data_q;
    assign buf_full  = buf_full_q;
    assign buf_len   = buf_len_q;
    assign buf_pid   = buf_pid_q;
    assign buf_endp  = buf_endp_q;
    assign buf_setup = buf_setup_q;
    assign rx_ack    = rx_ack_q;
    assign rx_nak    = rx_nak_q;
    assign rx_err    = rx_err_q;
endmodule

// File: tb/tb_usb_fs_rx_out_buffer.sv
// tb_usb_fs_rx_out_buffer: randomized self-checking bench against a transaction-level buffer model
module tb_usb_fs_rx_out_buffer;
    localparam int MAX_PKT = 64;
    localparam int NUM_EP  = 4;
    localparam int CNT_W   = 7;
    localparam logic [3:0] P_OUT = 4'b0001, P_SETUP = 4'b1101, P_IN = 4'b1001;
    localparam logic [3:0] P_D0 = 4'b0011, P_D1 = 4'b1011, P_D2 = 4'b0111;
    localparam logic [6:0] DEV = 7'h2A;

    logic clk = 1'b0, reset = 1'b1;
    logic [6:0] dev_addr = DEV, addr = '0;
    logic pkt_start = 0, pkt_end = 0, rx_data_put = 0, valid_packet = 0, buf_release = 0;
    logic [3:0] pid = '0, endp = '0;
    logic [7:0] rx_data = '0, rd_data;
    logic [CNT_W-1:0] rd_addr = '0, buf_len;
    logic buf_full, buf_setup, rx_ack, rx_nak, rx_err;
    logic [3:0] buf_pid, buf_endp;

    int checks = 0, errors = 0;

    logic m_full, m_setup;
    logic [CNT_W-1:0] m_len;
    logic [3:0] m_pid, m_endp;
    logic [7:0] m_data[$];

    always #5 clk = ~clk;

    usb_fs_rx_out_buffer #(.MAX_PKT(MAX_PKT), .NUM_EP(NUM_EP), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .dev_addr(dev_addr), .pkt_start(pkt_start), .pkt_end(pkt_end),
        .pid(pid), .addr(addr), .endp(endp), .rx_data_put(rx_data_put), .rx_data(rx_data),
        .valid_packet(valid_packet), .rd_addr(rd_addr), .rd_data(rd_data), .buf_release(buf_release),
        .buf_full(buf_full), .buf_len(buf_len), .buf_pid(buf_pid), .buf_endp(buf_endp),
        .buf_setup(buf_setup), .rx_ack(rx_ack), .rx_nak(rx_nak), .rx_err(rx_err)
    );

    task automatic model_reset();
        m_full = 0; m_setup = 0; m_len = '0; m_pid = '0; m_endp = '0;
        m_data.delete();
    endtask

    task automatic check_state(input string tag);
        checks++;
        if ({buf_full, buf_len, buf_pid, buf_endp, buf_setup} !== {m_full, m_len, m_pid, m_endp, m_setup}) begin
            errors++;
            $display("FAIL %s buf state: got full=%0d len=%0d pid=%h endp=%0d setup=%0d, expected full=%0d len=%0d pid=%h endp=%0d setup=%0d",
                     tag, buf_full, buf_len, buf_pid, buf_endp, buf_setup, m_full, m_len, m_pid, m_endp, m_setup);
        end
    endtask

    task automatic check_payload(input string tag);
        for (int i = 0; i < m_data.size(); i++) begin
            @(negedge clk) rd_addr = CNT_W'(i);
            @(negedge clk);
            checks++;
            if (rd_data !== m_data[i]) begin
                errors++;
                $display("FAIL %s rd_data[%0d]: got %h expected %h", tag, i, rd_data, m_data[i]);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({buf_full, buf_len, buf_pid, buf_endp, buf_setup, rx_ack, rx_nak, rx_err, rd_data} !== '0) begin
            errors++;
            $display("FAIL %s outputs not zero: full=%0d len=%0d pid=%h endp=%0d setup=%0d ack=%0d nak=%0d err=%0d rd=%h",
                     tag, buf_full, buf_len, buf_pid, buf_endp, buf_setup, rx_ack, rx_nak, rx_err, rd_data);
        end
    endtask

    task automatic send_token(input logic [3:0] tp, input logic [6:0] ta, input logic [3:0] te);
        @(negedge clk) pkt_start = 1;
        @(negedge clk) pkt_start = 0;
        repeat (2) @(negedge clk);
        pid = tp; addr = ta; endp = te; pkt_end = 1;
        @(negedge clk) pkt_end = 0; pid = '0; addr = '0; endp = '0;
    endtask

    // One token + data packet; the model decides the handshake from the protocol rules
    task automatic run_txn(input string tag, input logic [3:0] tp, input logic [6:0] ta, input logic [3:0] te,
                           input logic [3:0] dp, input int n, input logic v);
        logic [7:0] pl[$];
        int e_ack, e_nak, e_err, c_ack, c_nak, c_err;
        bit match, ok;
        for (int i = 0; i < n + 2; i++) pl.push_back(8'($urandom));
        match = (tp == P_OUT || tp == P_SETUP) && ta == DEV && int'(te) < NUM_EP;
        ok = v && (dp == P_D0 || dp == P_D1);
        e_ack = 0; e_nak = 0; e_err = 0;
        if (match) begin
            if (ok && m_full) e_nak = 1;
            else if (ok && n <= MAX_PKT) begin
                e_ack = 1; m_full = 1; m_len = CNT_W'(n); m_pid = dp; m_endp = te; m_setup = tp == P_SETUP;
                m_data = pl[0:n-1];
                if (n == 0) m_data.delete();
            end else e_err = 1;
        end
        send_token(tp, ta, te);
        repeat (2) @(negedge clk);
        pkt_start = 1;
        @(negedge clk) pkt_start = 0;
        foreach (pl[i]) begin
            rx_data = pl[i]; rx_data_put = 1;
            @(negedge clk) rx_data_put = 0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        pid = dp; pkt_end = 1; valid_packet = v;
        @(negedge clk) pkt_end = 0; pid = '0;
        c_ack = 0; c_nak = 0; c_err = 0;
        repeat (4) begin
            @(negedge clk);
            c_ack += int'(rx_ack); c_nak += int'(rx_nak); c_err += int'(rx_err);
        end
        valid_packet = 0;
        checks++;
        if (c_ack != e_ack || c_nak != e_nak || c_err != e_err) begin
            errors++;
            $display("FAIL %s pulses: got ack=%0d nak=%0d err=%0d expected ack=%0d nak=%0d err=%0d",
                     tag, c_ack, c_nak, c_err, e_ack, e_nak, e_err);
        end
        check_state(tag);
        if (e_ack == 1) check_payload(tag);
    endtask

    task automatic do_release(input string tag);
        @(negedge clk) buf_release = 1;
        @(negedge clk) buf_release = 0;
        m_full = 0;
        check_state(tag);
    endtask

    task automatic test_reset();
        reset = 1;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 0;
        @(negedge clk);
        check_state("after_reset");
    endtask

    task automatic test_commit();
        run_txn("commit_ep1", P_OUT, DEV, 4'd1, P_D0, 4, 1'b1);
    endtask

    task automatic test_nak_release();
        run_txn("nak_full", P_OUT, DEV, 4'd2, P_D1, 6, 1'b1);
        check_payload("nak_keep");
        do_release("release");
        do_release("release_idle");
    endtask

    task automatic test_overflow();
        run_txn("overflow", P_OUT, DEV, 4'd0, P_D0, MAX_PKT + 1, 1'b1);
        run_txn("max_pkt", P_OUT, DEV, 4'd3, P_D1, MAX_PKT, 1'b1);
        do_release("release_max");
    endtask

    task automatic test_filter();
        run_txn("wrong_addr", P_OUT, DEV ^ 7'h01, 4'd0, P_D0, 3, 1'b1);
        run_txn("wrong_ep", P_OUT, DEV, 4'(NUM_EP), P_D0, 3, 1'b1);
        run_txn("in_token", P_IN, DEV, 4'd0, P_D0, 3, 1'b1);
        run_txn("setup", P_SETUP, DEV, 4'd0, P_D0, 8, 1'b1);
        do_release("release_setup");
    endtask

    task automatic test_invalid_zero();
        run_txn("bad_crc", P_OUT, DEV, 4'd1, P_D0, 5, 1'b0);
        run_txn("bad_pid", P_OUT, DEV, 4'd1, P_D2, 5, 1'b1);
        run_txn("zero_len", P_OUT, DEV, 4'd2, P_D1, 0, 1'b1);
        do_release("release_zlp");
    endtask

    task automatic test_reset_mid();
        run_txn("pre_reset", P_OUT, DEV, 4'd3, P_D0, 3, 1'b1);
        send_token(P_OUT, DEV, 4'd1);
        @(negedge clk) pkt_start = 1;
        @(negedge clk) pkt_start = 0;
        repeat (3) begin
            rx_data = 8'($urandom); rx_data_put = 1;
            @(negedge clk) rx_data_put = 0;
        end
        reset = 1;
        model_reset();
        @(negedge clk);
        check_all_zero("reset_mid");
        reset = 0;
        run_txn("post_reset", P_OUT, DEV, 4'd1, P_D1, 5, 1'b1);
        do_release("release_post");
    endtask

    task automatic test_random();
        logic [3:0] tps[3] = '{P_OUT, P_SETUP, P_IN};
        logic [3:0] dps[3] = '{P_D0, P_D1, P_D2};
        for (int k = 0; k < 40; k++) begin
            if (m_full && $urandom_range(0, 1) == 1) do_release("rnd_release");
            run_txn("random", tps[$urandom_range(0, 2)],
                    ($urandom_range(0, 5) == 0) ? DEV ^ 7'($urandom_range(1, 127)) : DEV,
                    4'($urandom_range(0, NUM_EP)), dps[$urandom_range(0, 2)],
                    ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_PKT - 1, MAX_PKT + 2) : $urandom_range(0, 12),
                    $urandom_range(0, 4) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_nak_release();
        test_overflow();
        test_filter();
        test_invalid_zero();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
